// File: rtl/seq_divider_unit_pkg.sv
// Shared types and constants for the sequential radix-2 restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_e;

  localparam int DIV_WIDTH = 32;

  // Quotient reported for any division by zero.
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

  function automatic int div_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DIV_CNT_W = div_cnt_w(DIV_WIDTH);

endpackage

// File: rtl/seq_divider_unit_step.sv
// One combinational restoring-division iteration on a {remainder, quotient} pair.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             fits;

  // A set top remainder bit means the shifted value already exceeds any divisor.
  always_comb begin
    shifted = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, divisor_i};
    fits    = rem_i[WIDTH] | ~diff[WIDTH+1];
    if (fits) begin
      rem_o = diff[WIDTH:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted;
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider_unit.sv
// Multi-cycle signed/unsigned divider for the M-extension DIV/DIVU/REM/REMU ops,
// with a combinational same-cycle answer for division by zero.
module seq_divider_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             start,
  input  logic             signed_div,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             status,
  output logic             finished
);

  localparam int CW = div_cnt_w(WIDTH);

  div_state_e       state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_out_q, q_out_d;
  logic [WIDTH-1:0] r_out_q, r_out_d;

  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             div_zero;
  logic             dvd_neg;
  logic             dsr_neg;
  logic             zero_fast;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    (rem_q),
    .quo_i    (quo_q),
    .divisor_i(dsr_q),
    .rem_o    (rem_step),
    .quo_o    (quo_step)
  );

  assign div_zero  = (divisor == '0);
  assign dvd_neg   = signed_div & dividend[WIDTH-1];
  assign dsr_neg   = signed_div & divisor[WIDTH-1];
  assign zero_fast = (state_q == IDLE) && div_zero;
  assign quo_fix   = neg_quo_q ? -quo_step : quo_step;
  assign rem_fix   = neg_rem_q ? -rem_step[WIDTH-1:0] : rem_step[WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    q_out_d   = q_out_q;
    r_out_d   = r_out_q;
    case (state_q)
      IDLE: begin
        if (start && !div_zero) begin
          state_d   = BUSY;
          quo_d     = dvd_neg ? -dividend : dividend;
          dsr_d     = dsr_neg ? -divisor : divisor;
          neg_quo_d = signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_rem_d = dvd_neg;
          rem_d     = '0;
          cnt_d     = '0;
        end
      end
      BUSY: begin
        // A dropped start is a pipeline flush: leave without touching the results.
        if (!start) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = DONE;
            q_out_d = quo_fix;
            r_out_d = rem_fix;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      q_out_q   <= '0;
      r_out_q   <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsr_q     <= dsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      q_out_q   <= q_out_d;
      r_out_q   <= r_out_d;
    end
  end

  assign quotient  = zero_fast ? WIDTH'(DIV_ZERO_Q) : q_out_q;
  assign remainder = zero_fast ? dividend : r_out_q;
  assign status    = (state_q == BUSY);
  assign finished  = (state_q == DONE) || zero_fast;

endmodule

// File: tb/tb_seq_divider_unit.sv
// Scoreboard bench for seq_divider_unit: directed RISC-V corner cases plus random ops.
module tb_seq_divider_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         start;
  logic         signedDiv;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         status;
  logic         finished;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
  } expT;

  expT scoreQ[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  seq_divider_unit #(
    .WIDTH(W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dividend  (dividend),
    .divisor   (divisor),
    .start     (start),
    .signed_div(signedDiv),
    .quotient  (quotient),
    .remainder (remainder),
    .status    (status),
    .finished  (finished)
  );

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference RISC-V division semantics, including divide-by-zero and signed overflow.
  function automatic void refDiv(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                 output logic [W-1:0] q, output logic [W-1:0] r);
    int sa;
    int sbv;
    sa  = a;
    sbv = b;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = '0;
      end else begin
        q = 32'(sa / sbv);
        r = 32'(sa % sbv);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic pushExp(input logic [W-1:0] q, input logic [W-1:0] r);
    expT e;
    e.q = q;
    e.r = r;
    scoreQ.push_back(e);
  endtask

  task automatic popCheck(input string tag);
    expT e;
    if (scoreQ.size() == 0) begin
      checkOutput({tag, ":sbEmpty"}, 32'd1, 32'd0);
    end else begin
      e = scoreQ.pop_front();
      checkOutput({tag, ":quotient"}, quotient, e.q);
      checkOutput({tag, ":remainder"}, remainder, e.r);
    end
  endtask

  // Called #1 after a rising edge; that cycle is cycle 0 of the request.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                               input logic [W-1:0] expQ, input logic [W-1:0] expR,
                               input bit holdStart, input int latency, input string tag);
    int  busy = 0;
    int  k;
    bit  seen = 0;
    dividend  = a;
    divisor   = b;
    signedDiv = sgn;
    start     = 1'b1;
    pushExp(expQ, expR);
    for (k = 1; k <= latency + 5; k++) begin
      @(posedge clk);
      #1;
      if (k == latency - 30) begin
        dividend  = $urandom;
        divisor   = $urandom | 32'd1;
        signedDiv = ~sgn;
      end
      if (status) busy++;
      if (finished) begin
        seen = 1;
        break;
      end
    end
    checkOutput({tag, ":finishedSeen"}, 32'(seen), 32'd1);
    checkOutput({tag, ":latency"}, 32'(k), 32'(latency));
    checkOutput({tag, ":busyCycles"}, 32'(busy), 32'(W));
    checkOutput({tag, ":statusAtDone"}, 32'(status), 32'd0);
    popCheck(tag);
    if (!holdStart) start = 1'b0;
  endtask

  task automatic checkDivZero(input logic [W-1:0] a, input logic sgn, input string tag);
    dividend  = a;
    divisor   = '0;
    signedDiv = sgn;
    start     = 1'b1;
    pushExp(32'hFFFF_FFFF, a);
    #1;
    checkOutput({tag, ":finished"}, 32'(finished), 32'd1);
    checkOutput({tag, ":status"}, 32'(status), 32'd0);
    popCheck(tag);
    @(posedge clk);
    #1;
    checkOutput({tag, ":statusNext"}, 32'(status), 32'd0);
    checkOutput({tag, ":finishedNext"}, 32'(finished), 32'd1);
    start   = 1'b0;
    divisor = 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic countFinished(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (finished) pulses++;
    end
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         sgn;
    int           pulses;

    reset     = 1'b1;
    start     = 1'b0;
    dividend  = '0;
    divisor   = 32'd1;
    signedDiv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset:quotient", quotient, 32'd0);
    checkOutput("reset:remainder", remainder, 32'd0);
    checkOutput("reset:status", 32'(status), 32'd0);
    checkOutput("reset:finished", 32'(finished), 32'd0);

    applyStimulus(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33, "u100div7");
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("hold:quotient", quotient, 32'd14);
    checkOutput("hold:remainder", remainder, 32'd2);
    checkOutput("hold:finished", 32'(finished), 32'd0);

    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, "sNeg7div2");
    @(posedge clk);
    #1;
    applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 33, "s7divNeg2");
    @(posedge clk);
    #1;

    checkDivZero(32'd5, 1'b0, "u5div0");
    checkDivZero(32'd5, 1'b1, "s5div0");

    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33, "sOverflow");
    @(posedge clk);
    #1;
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0, 33, "uOverflowOps");
    @(posedge clk);
    #1;

    dividend  = 32'd100;
    divisor   = 32'd7;
    signedDiv = 1'b0;
    start     = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    checkOutput("midReset:busyBefore", 32'(status), 32'd1);
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("midReset:quotient", quotient, 32'd0);
    checkOutput("midReset:remainder", remainder, 32'd0);
    checkOutput("midReset:status", 32'(status), 32'd0);
    checkOutput("midReset:finished", 32'(finished), 32'd0);
    countFinished(40, pulses);
    checkOutput("midReset:noPulse", 32'(pulses), 32'd0);
    applyStimulus(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 33, "u9div3");
    @(posedge clk);
    #1;

    dividend  = 32'd1000;
    divisor   = 32'd10;
    signedDiv = 1'b0;
    start     = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort:status", 32'(status), 32'd0);
    countFinished(40, pulses);
    checkOutput("abort:noPulse", 32'(pulses), 32'd0);
    checkOutput("abort:quotientHeld", quotient, 32'd3);
    checkOutput("abort:remainderHeld", remainder, 32'd0);

    applyStimulus(32'd20, 32'd6, 1'b1, 32'd3, 32'd2, 1'b1, 33, "b2bFirst");
    applyStimulus(32'd20, 32'hFFFF_FFFA, 1'b1, 32'hFFFF_FFFD, 32'd2, 1'b0, 34, "b2bSecond");
    @(posedge clk);
    #1;

    for (int n = 0; n < 6; n++) begin
      a   = $urandom;
      b   = $urandom >> $urandom_range(0, 31);
      sgn = 1'($urandom_range(0, 1));
      if (b == '0) b = 32'd3;
      refDiv(a, b, sgn, q, r);
      applyStimulus(a, b, sgn, q, r, 1'b0, 33, $sformatf("rand%0d", n));
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
